pipeline_hazard_ctrl: RTL and testbench

Hazard and stall/flush scheduler for the 5-stage core (F, D, E, M, W). It watches register usage in D, load/MDU activity in E, data-memory handshake in M and branch resolution in E. From these it drives the hold/flush controls of the PC and of the FD, DE and EM pipeline registers. It replaces the scattered stall logic: every pipeline register takes its hold/flush from this block only.

---
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall/flush scheduler for the 5-stage core: derives PC and
// FD/DE/EM hold/flush controls from load-use, branch, MDU and data-memory events.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_en_i,
    input  logic              id_rs2_en_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_load_i,
    input  logic              branch_taken_i,
    input  logic              mdu_start_i,
    input  logic              mdu_done_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ack_i,
    output logic              pc_stop_o,
    output logic              fd_hold_o,
    output logic              fd_flush_o,
    output logic              de_hold_o,
    output logic              de_flush_o,
    output logic              em_hold_o,
    output logic              em_flush_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              mdu_timeout_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    localparam int unsigned     TMO_W    = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MDU_TIMEOUT - 1);

    state_t             state, state_n;
    logic               mdu_pend, mdu_pend_n;
    logic               done_seen, done_seen_n;
    logic [TMO_W-1:0]   tmo, tmo_n, tmo_inc;
    logic               timeout_flag;
    logic               abort;
    logic               mem_stall, load_use;
    logic               pc_stop, fd_hold, fd_flush, de_hold, de_flush, em_hold, em_flush;

    assign mem_stall = dmem_req_i & ~dmem_ack_i;
    assign load_use  = ex_load_i & (ex_rd_i != '0) &
                       ((id_rs1_en_i & (id_rs1_i == ex_rd_i)) |
                        (id_rs2_en_i & (id_rs2_i == ex_rd_i)));

    always_comb begin
        state_n     = state;
        mdu_pend_n  = mdu_pend;
        done_seen_n = done_seen;
        tmo_n       = tmo;
        tmo_inc     = (tmo == TMO_LAST) ? tmo : tmo + TMO_W'(1);
        abort       = 1'b0;
        pc_stop     = 1'b0;
        fd_hold     = 1'b0;
        fd_flush    = 1'b0;
        de_hold     = 1'b0;
        de_flush    = 1'b0;
        em_hold     = 1'b0;
        em_flush    = 1'b0;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    {pc_stop, fd_hold, de_hold, em_hold} = '1;
                    state_n    = MEM_WAIT;
                    mdu_pend_n = 1'b0;
                end else if (branch_taken_i) begin
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                end else if (mdu_start_i && !mdu_done_i) begin
                    {pc_stop, fd_hold, de_hold, em_flush} = '1;
                    state_n = MDU_WAIT;
                    tmo_n   = TMO_W'(1);
                end else if (load_use) begin
                    {pc_stop, fd_hold, de_flush} = '1;
                end
            end

            MDU_WAIT: begin
                if (mem_stall) begin
                    // MEM_WAIT must know to return here unless done already arrived
                    {pc_stop, fd_hold, de_hold, em_hold} = '1;
                    state_n     = MEM_WAIT;
                    mdu_pend_n  = 1'b1;
                    tmo_n       = tmo_inc;
                    done_seen_n = done_seen | mdu_done_i;
                end else if (mdu_done_i || done_seen) begin
                    state_n     = RUN;
                    tmo_n       = '0;
                    done_seen_n = 1'b0;
                    mdu_pend_n  = 1'b0;
                end else if (tmo == TMO_LAST) begin
                    abort       = 1'b1;
                    de_flush    = 1'b1;
                    state_n     = RUN;
                    tmo_n       = '0;
                    mdu_pend_n  = 1'b0;
                end else begin
                    {pc_stop, fd_hold, de_hold, em_flush} = '1;
                    tmo_n = tmo_inc;
                end
            end

            MEM_WAIT: begin
                if (mem_stall) begin
                    {pc_stop, fd_hold, de_hold, em_hold} = '1;
                    if (mdu_pend) begin
                        tmo_n       = tmo_inc;
                        done_seen_n = done_seen | mdu_done_i;
                    end
                end else if (mdu_pend && !done_seen && !mdu_done_i) begin
                    state_n = MDU_WAIT;
                    tmo_n   = tmo_inc;
                end else begin
                    state_n     = RUN;
                    tmo_n       = '0;
                    done_seen_n = 1'b0;
                    mdu_pend_n  = 1'b0;
                end
            end

            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= RUN;
            mdu_pend     <= 1'b0;
            done_seen    <= 1'b0;
            tmo          <= '0;
            timeout_flag <= 1'b0;
            stall_cnt_o  <= '0;
        end else begin
            state     <= state_n;
            mdu_pend  <= mdu_pend_n;
            done_seen <= done_seen_n;
            tmo       <= tmo_n;
            if (abort)
                timeout_flag <= 1'b1;
            if (pc_stop_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

    // Gated by reset so input-driven hazards cannot leak out while held in reset
    assign pc_stop_o     = rst_n_i & pc_stop;
    assign fd_hold_o     = rst_n_i & fd_hold;
    assign fd_flush_o    = rst_n_i & fd_flush;
    assign de_hold_o     = rst_n_i & de_hold;
    assign de_flush_o    = rst_n_i & de_flush;
    assign em_hold_o     = rst_n_i & em_hold;
    assign em_flush_o    = rst_n_i & em_flush;
    assign state_o       = state;
    assign mdu_timeout_o = rst_n_i & (timeout_flag | abort);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MDU_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100100;
    localparam logic [6:0] BR   = 7'b0010100;
    localparam logic [6:0] MDU  = 7'b1101001;
    localparam logic [6:0] MEM  = 7'b1101010;
    localparam logic [6:0] TMO  = 7'b0000100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_en, rs2_en, ld, br, mstart, mdone, req, ack;
    logic        pc_stop, fd_hold, fd_flush, de_hold, de_flush, em_hold, em_flush;
    logic [1:0]  state;
    logic [31:0] cnt;
    logic        tmo_flag;
    logic [6:0]  ctl;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    pipeline_hazard_ctrl #(.REG_AW(5), .MDU_TIMEOUT(8), .CNT_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_en_i(rs1_en), .id_rs2_en_i(rs2_en),
        .ex_rd_i(rd), .ex_load_i(ld), .branch_taken_i(br),
        .mdu_start_i(mstart), .mdu_done_i(mdone),
        .dmem_req_i(req), .dmem_ack_i(ack),
        .pc_stop_o(pc_stop), .fd_hold_o(fd_hold), .fd_flush_o(fd_flush),
        .de_hold_o(de_hold), .de_flush_o(de_flush),
        .em_hold_o(em_hold), .em_flush_o(em_flush),
        .state_o(state), .stall_cnt_o(cnt), .mdu_timeout_o(tmo_flag)
    );

    assign ctl = {pc_stop, fd_hold, fd_flush, de_hold, de_flush, em_hold, em_flush};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check combinational controls mid-cycle, then advance past the next edge
    task automatic step_chk(input string tag, input logic [6:0] ctl_e,
                            input logic [1:0] st_e, input logic tmo_e);
        @(negedge clk);
        chk({tag, ".ctl"}, {25'd0, ctl}, {25'd0, ctl_e});
        chk({tag, ".state"}, {30'd0, state}, {30'd0, st_e});
        chk({tag, ".tmo"}, {31'd0, tmo_flag}, {31'd0, tmo_e});
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rs1 = '0; rs2 = '0; rd = '0; rs1_en = 0; rs2_en = 0; ld = 0;
        br = 0; mstart = 0; mdone = 0; req = 0; ack = 0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        ld = 1; rd = 5'd5; rs1 = 5'd5; rs1_en = 1;
        #3;
        chk("rst.ctl", {25'd0, ctl}, 32'd0);
        chk("rst.state", {30'd0, state}, 32'd0);
        chk("rst.cnt", cnt, 32'd0);
        chk("rst.tmo", {31'd0, tmo_flag}, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load-use: one bubble
        ld = 1; rd = 5'd5; rs1 = 5'd5; rs1_en = 1;
        step_chk("lu", LU, 2'd0, 1'b0);
        idle();
        chk("lu.cnt", cnt, 32'd1);
        step_chk("lu.after", NONE, 2'd0, 1'b0);

        // x0 destination never hazards
        ld = 1; rd = 5'd0; rs1 = 5'd0; rs1_en = 1;
        step_chk("lu.x0", NONE, 2'd0, 1'b0);
        // matching rs2 that is not actually read
        ld = 1; rd = 5'd7; rs2 = 5'd7; rs2_en = 0;
        step_chk("lu.rs2off", NONE, 2'd0, 1'b0);
        // matching rs2 that is read
        rs2_en = 1;
        step_chk("lu.rs2", LU, 2'd0, 1'b0);
        idle();
        chk("lu.rs2.cnt", cnt, 32'd2);

        // branch outranks load-use
        br = 1; ld = 1; rd = 5'd3; rs1 = 5'd3; rs1_en = 1;
        step_chk("br", BR, 2'd0, 1'b0);
        idle();
        chk("br.cnt", cnt, 32'd2);

        // MDU: start t0, done t0+4
        mstart = 1;
        step_chk("mdu.t0", MDU, 2'd0, 1'b0);
        mstart = 0;
        for (int i = 1; i <= 3; i++) step_chk("mdu.wait", MDU, 2'd2, 1'b0);
        mdone = 1;
        step_chk("mdu.done", NONE, 2'd2, 1'b0);
        mdone = 0;
        step_chk("mdu.run", NONE, 2'd0, 1'b0);
        chk("mdu.cnt", cnt, 32'd6);

        // start with done in the same cycle: no stall
        mstart = 1; mdone = 1;
        step_chk("mdu.fast", NONE, 2'd0, 1'b0);
        idle();

        // ack in the first request cycle costs nothing
        req = 1; ack = 1;
        step_chk("mem.fast", NONE, 2'd0, 1'b0);
        // ack two cycles after request
        ack = 0;
        step_chk("mem.t0", MEM, 2'd0, 1'b0);
        br = 1;
        step_chk("mem.t1", MEM, 2'd1, 1'b0);
        br = 0; ack = 1;
        step_chk("mem.ack", NONE, 2'd1, 1'b0);
        idle();
        step_chk("mem.run", NONE, 2'd0, 1'b0);
        chk("mem.cnt", cnt, 32'd8);

        // memory stall inside MDU wait, done arrives during MEM_WAIT
        mstart = 1;
        step_chk("mm.t0", MDU, 2'd0, 1'b0);
        mstart = 0; req = 1;
        step_chk("mm.t1", MEM, 2'd2, 1'b0);
        mdone = 1;
        step_chk("mm.t2", MEM, 2'd1, 1'b0);
        mdone = 0; br = 1;
        step_chk("mm.t3", MEM, 2'd1, 1'b0);
        br = 0;
        step_chk("mm.t4", MEM, 2'd1, 1'b0);
        ack = 1;
        step_chk("mm.t5", NONE, 2'd1, 1'b0);
        idle();
        step_chk("mm.t6", NONE, 2'd0, 1'b0);
        chk("mm.cnt", cnt, 32'd13);

        // MDU timeout: abort on t0+7
        mstart = 1;
        step_chk("to.t0", MDU, 2'd0, 1'b0);
        mstart = 0;
        for (int i = 1; i <= 6; i++) step_chk("to.wait", MDU, 2'd2, 1'b0);
        step_chk("to.abort", TMO, 2'd2, 1'b1);
        step_chk("to.run", NONE, 2'd0, 1'b1);
        step_chk("to.sticky", NONE, 2'd0, 1'b1);
        chk("to.cnt", cnt, 32'd20);

        // asynchronous reset in the middle of MEM_WAIT
        req = 1;
        step_chk("rm.t0", MEM, 2'd0, 1'b1);
        step_chk("rm.t1", MEM, 2'd1, 1'b1);
        chk("rm.cnt", cnt, 32'd22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm.ctl", {25'd0, ctl}, 32'd0);
        chk("rm.state", {30'd0, state}, 32'd0);
        chk("rm.cnt0", cnt, 32'd0);
        chk("rm.tmo", {31'd0, tmo_flag}, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step_chk("rm.resume", NONE, 2'd0, 1'b0);
        chk("rm.cnt1", cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
